// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM sequencing each instruction
// through its datapath steps, plus retired-instruction and cycle counters
// used for CPI measurement. SYSTEM and unknown opcodes park the FSM in HALT.
module controle_multiciclo (
  input  logic        clockCPU,
  input  logic        reset,
  input  logic [6:0]  iOpcode,
  output logic [3:0]  oEstado,
  output logic        oEscrevePC,
  output logic        oEscrevePCCond,
  output logic        oIouD,
  output logic        oLeMem,
  output logic        oEscreveMem,
  output logic        oEscreveIR,
  output logic        oEscreveReg,
  output logic [1:0]  oOrigAULA,
  output logic [1:0]  oOrigBULA,
  output logic [1:0]  oMem2Reg,
  output logic [1:0]  oOrigPC,
  output logic [1:0]  oALUOp,
  output logic        oHalt,
  output logic [31:0] oInstrCount,
  output logic [31:0] oCycleCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_RSV13  = 4'd13,
    S_RSV14  = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      state_q, state_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        retire;

  // State register and counters; reset aborts any in-flight instruction.
  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= 32'd0;
      cycle_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // An instruction retires on the edge leaving its final state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JAL, S_JALR: retire = 1'b1;
      default: retire = 1'b0;
    endcase
    instr_cnt_d = retire ? instr_cnt_q + 32'd1 : instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  // Next-state: opcode steers the path after DECODE and after MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (iOpcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (iOpcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_LUI:    state_d = S_ALUWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs from the state register; reset masks every enable.
  always_comb begin
    oEscrevePC     = 1'b0;
    oEscrevePCCond = 1'b0;
    oIouD          = 1'b0;
    oLeMem         = 1'b0;
    oEscreveMem    = 1'b0;
    oEscreveIR     = 1'b0;
    oEscreveReg    = 1'b0;
    oOrigAULA      = 2'd0;
    oOrigBULA      = 2'd0;
    oMem2Reg       = 2'd0;
    oOrigPC        = 2'd0;
    oALUOp         = 2'd0;
    oHalt          = 1'b0;
    case (state_q)
      S_FETCH: begin
        oLeMem = 1'b1; oEscreveIR = 1'b1; oEscrevePC = 1'b1;
        oOrigBULA = 2'd2;
      end
      S_DECODE: begin
        oOrigAULA = 2'd1; oOrigBULA = 2'd1;
      end
      S_MEMADR: begin
        oOrigAULA = 2'd2; oOrigBULA = 2'd1;
      end
      S_MEMRD: begin
        oIouD = 1'b1; oLeMem = 1'b1;
      end
      S_MEMWB: begin
        oEscreveReg = 1'b1; oMem2Reg = 2'd1;
      end
      S_MEMWR: begin
        oIouD = 1'b1; oEscreveMem = 1'b1;
      end
      S_EXEC_R: begin
        oOrigAULA = 2'd2; oOrigBULA = 2'd0; oALUOp = 2'd2;
      end
      S_EXEC_I: begin
        oOrigAULA = 2'd2; oOrigBULA = 2'd1; oALUOp = 2'd2;
      end
      S_ALUWB: begin
        oEscreveReg = 1'b1; oMem2Reg = 2'd0;
      end
      S_BRANCH: begin
        oOrigAULA = 2'd2; oOrigBULA = 2'd0; oALUOp = 2'd1;
        oEscrevePCCond = 1'b1; oOrigPC = 2'd1;
      end
      S_JAL: begin
        // rd gets the pre-edge PC (OldPC + 4) while PC takes ALUOut.
        oEscreveReg = 1'b1; oMem2Reg = 2'd2;
        oEscrevePC = 1'b1; oOrigPC = 2'd1;
      end
      S_JALR: begin
        oOrigAULA = 2'd2; oOrigBULA = 2'd1; oALUOp = 2'd0;
        oEscreveReg = 1'b1; oMem2Reg = 2'd2;
        oEscrevePC = 1'b1; oOrigPC = 2'd2;
      end
      S_LUI: begin
        oOrigAULA = 2'd3; oOrigBULA = 2'd1;
      end
      S_HALT:  oHalt = 1'b1;
      default: ;
    endcase
    if (reset) begin
      oEscrevePC     = 1'b0;
      oEscrevePCCond = 1'b0;
      oLeMem         = 1'b0;
      oEscreveMem    = 1'b0;
      oEscreveIR     = 1'b0;
      oEscreveReg    = 1'b0;
      oHalt          = 1'b0;
    end
  end

  assign oEstado     = state_q;
  assign oInstrCount = instr_cnt_q;
  assign oCycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: a driver issues opcodes and pushes the
// expected per-cycle output vector; a negedge monitor pops and compares.
module tb_controle_multiciclo;

  localparam int W = 86; // state(4) + ctrl(18) + instr(32) + cycle(32)

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  iOpcode;
  logic [3:0]  oEstado;
  logic        oEscrevePC, oEscrevePCCond, oIouD, oLeMem, oEscreveMem;
  logic        oEscreveIR, oEscreveReg, oHalt;
  logic [1:0]  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oALUOp;
  logic [31:0] oInstrCount, oCycleCount;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  bit           mon_en = 1'b0;
  logic [31:0]  m_cyc, m_instr;

  // Clock
  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clockCPU(clk), .reset(reset), .iOpcode(iOpcode), .oEstado(oEstado),
    .oEscrevePC(oEscrevePC), .oEscrevePCCond(oEscrevePCCond), .oIouD(oIouD),
    .oLeMem(oLeMem), .oEscreveMem(oEscreveMem), .oEscreveIR(oEscreveIR),
    .oEscreveReg(oEscreveReg), .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA),
    .oMem2Reg(oMem2Reg), .oOrigPC(oOrigPC), .oALUOp(oALUOp), .oHalt(oHalt),
    .oInstrCount(oInstrCount), .oCycleCount(oCycleCount)
  );

  // Per-state control word taken from the state table:
  // {pc, pccond, iord, lemem, escmem, escir, escreg, A, B, m2r, origpc, aluop, halt}
  function automatic logic [17:0] ctrl_of(input int s);
    logic pc, cond, iord, le, wm, ir, wr, h;
    logic [1:0] a, b, m2r, opc, alu;
    {pc, cond, iord, le, wm, ir, wr, h} = 8'd0;
    {a, b, m2r, opc, alu} = 10'd0;
    case (s)
      0:  begin le = 1; ir = 1; pc = 1; b = 2; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin iord = 1; le = 1; end
      4:  begin wr = 1; m2r = 1; end
      5:  begin iord = 1; wm = 1; end
      6:  begin a = 2; b = 0; alu = 2; end
      7:  begin a = 2; b = 1; alu = 2; end
      8:  begin wr = 1; end
      9:  begin a = 2; alu = 1; cond = 1; opc = 1; end
      10: begin wr = 1; m2r = 2; pc = 1; opc = 1; end
      11: begin a = 2; b = 1; wr = 1; m2r = 2; pc = 1; opc = 2; end
      12: begin a = 3; b = 1; end
      15: begin h = 1; end
      default: ;
    endcase
    return {pc, cond, iord, le, wm, ir, wr, a, b, m2r, opc, alu, h};
  endfunction

  // Reference path of each instruction class as a list of visited states.
  function automatic void path_of(input logic [6:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      7'b0000011: p = {p, 2, 3, 4};
      7'b0100011: p = {p, 2, 5};
      7'b0110011: p = {p, 6, 8};
      7'b0010011: p = {p, 7, 8};
      7'b0110111: p = {p, 12, 8};
      7'b0010111: p = {p, 8};
      7'b1100011: p = {p, 9};
      7'b1101111: p = {p, 10};
      7'b1100111: p = {p, 11};
      default:    p = {p, 15};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enables();
    return {oEscrevePC, oEscrevePCCond, oLeMem, oEscreveMem, oEscreveIR, oEscreveReg, oHalt};
  endfunction

  // Driver: issue one instruction (plus extra HALT cycles), push expectations.
  task automatic run_instr(input logic [6:0] op, input int extra_halt);
    int p[$];
    path_of(op, p);
    for (int i = 0; i < extra_halt; i++) p.push_back(15);
    iOpcode = op;
    foreach (p[i]) begin
      exp_q.push_back({p[i][3:0], ctrl_of(p[i]), m_instr, m_cyc});
      m_cyc = m_cyc + 32'd1;
    end
    if (p[p.size()-1] != 15) m_instr = m_instr + 32'd1;
    repeat (p.size()) @(posedge clk);
    #2;
  endtask

  // Reset: checks asynchronous clear and enable masking across an edge,
  // then releases just after a posedge with the FSM sitting in FETCH.
  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk({tag, "_rst_state"}, {28'd0, oEstado}, 32'd0);
    chk({tag, "_rst_instr"}, oInstrCount, 32'd0);
    chk({tag, "_rst_cycle"}, oCycleCount, 32'd0);
    chk({tag, "_rst_en"}, {25'd0, enables()}, 32'd0);
    @(posedge clk); #2;
    chk({tag, "_rst_hold_en"}, {25'd0, enables()}, 32'd0);
    chk({tag, "_rst_hold_sel"}, {28'd0, oOrigBULA, oIouD, 1'b0}, {28'd0, 2'd2, 1'b0, 1'b0});
    chk({tag, "_rst_hold_cyc"}, oCycleCount, 32'd0);
    reset = 1'b0;
    m_cyc = 32'd0;
    m_instr = 32'd0;
    mon_en = 1'b1;
  endtask

  // Monitor: every negedge the DUT presents a full output vector.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      logic [W-1:0] act, exp;
      act = {oEstado, oEscrevePC, oEscrevePCCond, oIouD, oLeMem, oEscreveMem,
             oEscreveIR, oEscreveReg, oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC,
             oALUOp, oHalt, oInstrCount, oCycleCount};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underflow: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL sb_cycle: got %h expected %h (state %0d/%0d)",
                   act, exp, act[W-1 -: 4], exp[W-1 -: 4]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] legal_ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b0000011};

  initial begin
    reset = 1'b1;
    iOpcode = 7'd0;
    m_cyc = 32'd0;
    m_instr = 32'd0;
    #2;
    do_reset("init");

    // Directed: ADDI, LW, SW, BEQ, JAL, JALR, AUIPC, LUI, R-type
    run_instr(7'b0010011, 0);
    chk("addi_instr", oInstrCount, 32'd1);
    chk("addi_cycle", oCycleCount, 32'd4);
    run_instr(7'b0000011, 0);
    run_instr(7'b0100011, 0);
    run_instr(7'b1100011, 0);
    run_instr(7'b1101111, 0);
    run_instr(7'b1100111, 0);
    run_instr(7'b0010111, 0);
    run_instr(7'b0110111, 0);
    run_instr(7'b0110011, 0);

    // Random instruction mix
    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(0, 9)], 0);

    // Reset in the middle of a load (while in MEMRD)
    mon_en = 1'b0;
    iOpcode = 7'b0000011;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_ld_state", {28'd0, oEstado}, 32'd3);
    chk("mid_ld_rd", {30'd0, oLeMem, oIouD}, 32'd3);
    do_reset("mid");
    run_instr(7'b0010011, 0);

    // Cycle counter wrap
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_q;
    m_cyc = 32'hFFFF_FFFE;
    run_instr(7'b1101111, 0);
    chk("wrap_cycle", oCycleCount, 32'd1);
    for (int i = 0; i < 3; i++)
      run_instr(legal_ops[$urandom_range(0, 9)], 0);

    // Halt on SYSTEM or zero opcode, held for 20 further cycles
    do_reset("halt");
    run_instr(7'b0110011, 0);
    run_instr(($urandom_range(0, 1) == 1) ? 7'b1110011 : 7'b0000000, 20);
    chk("halt_flag", {31'd0, oHalt}, 32'd1);
    chk("halt_instr", oInstrCount, 32'd1);
    chk("halt_cycle", oCycleCount, 32'd27);
    mon_en = 1'b0;

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Moore-style control FSM for the multicycle RISC-V datapath. It sits inside the multicycle CPU next to the datapath registers (PC, OldPC, IR, MDR, A, B, ALUOut). Each instruction runs as a sequence of states, and each state drives the write enables and mux selects for that step. It also keeps retired-instruction and cycle counters for CPI measurement, and stops in a HALT state on SYSTEM or unknown opcodes.

## Interface
- No parameters.
- clockCPU  in  1  CPU clock (the divided clock); all state changes on its rising edge.
- reset  in  1  Asynchronous, active-high.
- iOpcode  in  7  IR[6:0]; valid from DECODE onward.
- oEstado  out  4  Current state encoding.
- oEscrevePC  out  1  Unconditional PC write.
- oEscrevePCCond  out  1  PC write if the datapath branch condition is true.
- oIouD  out  1  Memory address select: 0 = PC, 1 = ALUOut.
- oLeMem  out  1  Memory read.
- oEscreveMem  out  1  Memory write.
- oEscreveIR  out  1  Load IR and OldPC.
- oEscreveReg  out  1  Register file write of rd.
- oOrigAULA  out  2  ALU A select: 0 = PC, 1 = OldPC, 2 = regA, 3 = zero.
- oOrigBULA  out  2  ALU B select: 0 = regB, 1 = imm, 2 = constant 4, 3 = reserved (treat as 0).
- oMem2Reg  out  2  Write-back select: 0 = ALUOut, 1 = MDR, 2 = PC.
- oOrigPC  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = ALU result with bit0 cleared.
- oALUOp  out  2  0 = add, 1 = branch compare (funct3 decoded downstream), 2 = funct decode.
- oHalt  out  1  High in HALT.
- oInstrCount  out  32  Retired instructions.
- oCycleCount  out  32  clockCPU cycles since reset.

## Operation
- Outputs are decoded combinationally from the state register only (Moore). oEstado is the state register.
- States and encodings:
  - FETCH = 0: IouD = 0, LeMem, EscreveIR, A = 0, B = 2, ALUOp = 0, OrigPC = 0, EscrevePC. Next: DECODE.
  - DECODE = 1: A = 1, B = 1, ALUOp = 0 (ALUOut <= OldPC + imm). Next by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → ALUWB (AUIPC uses the DECODE ALUOut)
    - anything else, including 1110011 → HALT
  - MEMADR = 2: A = 2, B = 1, ALUOp = 0. Next: MEMRD if opcode 0000011, else MEMWR.
  - MEMRD = 3: IouD = 1, LeMem. Next: MEMWB.
  - MEMWB = 4: EscreveReg, Mem2Reg = 1. Next: FETCH.
  - MEMWR = 5: IouD = 1, EscreveMem. Next: FETCH.
  - EXEC_R = 6: A = 2, B = 0, ALUOp = 2. Next: ALUWB.
  - EXEC_I = 7: A = 2, B = 1, ALUOp = 2. Next: ALUWB.
  - ALUWB = 8: EscreveReg, Mem2Reg = 0. Next: FETCH.
  - BRANCH = 9: A = 2, B = 0, ALUOp = 1, EscrevePCCond, OrigPC = 1. Next: FETCH.
  - JAL = 10: EscreveReg, Mem2Reg = 2, EscrevePC, OrigPC = 1. Next: FETCH.
  - JALR = 11: A = 2, B = 1, ALUOp = 0, EscreveReg, Mem2Reg = 2, EscrevePC, OrigPC = 2. Next: FETCH.
  - LUI = 12: A = 3, B = 1, ALUOp = 0. Next: ALUWB.
  - HALT = 15: all enables 0, oHalt = 1. Stays until reset.
  - Encodings 13 and 14: all enables 0. Next: FETCH.
- Every signal not listed for a state is 0.
- JAL and JALR write rd and PC on the same edge. rd receives the pre-edge PC, which is OldPC + 4.
- oInstrCount increments (mod 2^32) on each edge where the current state is MEMWB, MEMWR, ALUWB, BRANCH, JAL or JALR.
- oCycleCount increments (mod 2^32) every edge, including while in HALT.

## Timing
- Reset asserted: state = FETCH and both counters = 0, asynchronously.
- While reset is high, all write/read enables (EscrevePC, EscrevePCCond, LeMem, EscreveMem, EscreveIR, EscreveReg) are forced to 0. Selects show FETCH values; oHalt = 0.
- The first FETCH executes on the first rising edge after reset deasserts.
- Cycles per instruction:
  - load 5
  - store, R, I, LUI 4
  - AUIPC, branch, JAL, JALR 3
- Reset mid-instruction aborts it immediately; the counter does not increment for the aborted instruction.
- Counter wrap: 0xFFFFFFFF → 0 with no flag.

## Test plan
- Reset, then an ADDI sequence (0010011): oEstado = 0, 1, 7, 8, 0. oInstrCount = 1 after 4 cycles; oCycleCount = 4.
- LW (0000011): states 0, 1, 2, 3, 4. LeMem = 1 with IouD = 1 in state 3; EscreveReg with Mem2Reg = 1 in state 4. SW: states 0, 1, 2, 5 with EscreveMem only in 5.
- BEQ, JAL, JALR, AUIPC: each takes 3 cycles. JALR shows OrigPC = 2, Mem2Reg = 2, EscrevePC = EscreveReg = 1 in state 11. AUIPC goes 1 → 8.
- Opcode 1110011 or 0000000: 0 → 1 → 15. oHalt = 1 and oInstrCount frozen for 20 cycles while oCycleCount advances by 20.
- Reset pulse while in state 3: oEstado = 0 and counters = 0 without a clock edge. Enables stay 0 until reset falls.
- Preload oCycleCount near 0xFFFFFFFF (force or a long run): after the wrap it reads 0x00000000.
